// File: rtl/pkt_switch.sv
// NUM_PORTS x NUM_PORTS packet switch: per-output round-robin arbitration into show-ahead FIFOs.
// Define PKT_SWITCH_BCAST_EN to deliver all-ones addressed words to every output.
module pkt_switch #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_PORTS*ADDR_W-1:0] addr_in,
  input  logic [NUM_PORTS*DATA_W-1:0] data_in,
  input  logic [NUM_PORTS-1:0]        valid_in,
  output logic [NUM_PORTS-1:0]        rcv_rdy,
  output logic [NUM_PORTS*ADDR_W-1:0] addr_out,
  output logic [NUM_PORTS*DATA_W-1:0] data_out,
  output logic [NUM_PORTS-1:0]        valid_out,
  input  logic [NUM_PORTS-1:0]        data_rd
);

  localparam int LOG_P = $clog2(NUM_PORTS);
  localparam int LOG_D = $clog2(FIFO_DEPTH);
  localparam int ENT_W = ADDR_W + DATA_W;
  localparam logic [LOG_D:0] FULL_CNT = (LOG_D+1)'(FIFO_DEPTH);

  logic [ENT_W-1:0]     mem_q    [NUM_PORTS][FIFO_DEPTH];
  logic [LOG_D-1:0]     wr_ptr_q [NUM_PORTS];
  logic [LOG_D-1:0]     wr_ptr_d [NUM_PORTS];
  logic [LOG_D-1:0]     rd_ptr_q [NUM_PORTS];
  logic [LOG_D-1:0]     rd_ptr_d [NUM_PORTS];
  logic [LOG_D:0]       count_q  [NUM_PORTS];
  logic [LOG_D:0]       count_d  [NUM_PORTS];
  logic [LOG_P-1:0]     rr_ptr_q [NUM_PORTS];
  logic [LOG_P-1:0]     rr_ptr_d [NUM_PORTS];
  logic [NUM_PORTS-1:0] req      [NUM_PORTS];  // req[j][i]: input i requests output j
  logic [ENT_W-1:0]     wr_ent   [NUM_PORTS];
  logic [NUM_PORTS-1:0] full, push, pop, uc_gnt;
`ifdef PKT_SWITCH_BCAST_EN
  logic [NUM_PORTS-1:0] bc_req, bc_gnt;
  logic [LOG_P-1:0]     bc_rr_q, bc_rr_d;
  logic                 any_uc;
`endif

  always_comb begin
    for (int j = 0; j < NUM_PORTS; j++) req[j] = '0;
`ifdef PKT_SWITCH_BCAST_EN
    bc_req = '0;
    any_uc = 1'b0;
`endif
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (valid_in[i]) begin
`ifdef PKT_SWITCH_BCAST_EN
        if (&addr_in[i*ADDR_W +: ADDR_W]) bc_req[i] = 1'b1;
        else
`endif
          req[addr_in[i*ADDR_W +: LOG_P]][i] = 1'b1;
      end
    end
`ifdef PKT_SWITCH_BCAST_EN
    for (int j = 0; j < NUM_PORTS; j++) any_uc = any_uc | (|req[j]);
`endif
  end

  always_comb begin
    logic [LOG_P-1:0] idx;
    uc_gnt   = '0;
    push     = '0;
    full     = '0;
    rr_ptr_d = rr_ptr_q;
    idx      = '0;
    for (int j = 0; j < NUM_PORTS; j++) wr_ent[j] = '0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      // Full is judged on the registered count, so a same-cycle pop cannot free a slot.
      full[j] = (count_q[j] == FULL_CNT);
      if (!full[j]) begin
        for (int k = 0; k < NUM_PORTS; k++) begin
          idx = rr_ptr_q[j] + LOG_P'(k);
          if (!push[j] && req[j][idx]) begin
            push[j]     = 1'b1;
            uc_gnt[idx] = 1'b1;
            wr_ent[j]   = {addr_in[idx*ADDR_W +: ADDR_W], data_in[idx*DATA_W +: DATA_W]};
            rr_ptr_d[j] = idx + LOG_P'(1);
          end
        end
      end
    end
`ifdef PKT_SWITCH_BCAST_EN
    bc_gnt  = '0;
    bc_rr_d = bc_rr_q;
    if (!any_uc && !(|full)) begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        idx = bc_rr_q + LOG_P'(k);
        if (!(|bc_gnt) && bc_req[idx]) begin
          bc_gnt[idx] = 1'b1;
          push        = '1;
          for (int j = 0; j < NUM_PORTS; j++)
            wr_ent[j] = {addr_in[idx*ADDR_W +: ADDR_W], data_in[idx*DATA_W +: DATA_W]};
          bc_rr_d = idx + LOG_P'(1);
        end
      end
    end
    rcv_rdy = reset ? '0 : (uc_gnt | bc_gnt);
`else
    rcv_rdy = reset ? '0 : uc_gnt;
`endif
  end

  always_comb begin
    pop       = '0;
    valid_out = '0;
    addr_out  = '0;
    data_out  = '0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      valid_out[j] = (count_q[j] != '0);
      pop[j]       = data_rd[j] && valid_out[j];
      wr_ptr_d[j]  = push[j] ? wr_ptr_q[j] + LOG_D'(1) : wr_ptr_q[j];
      rd_ptr_d[j]  = pop[j]  ? rd_ptr_q[j] + LOG_D'(1) : rd_ptr_q[j];
      count_d[j]   = count_q[j];
      if (push[j] && !pop[j])      count_d[j] = count_q[j] + (LOG_D+1)'(1);
      else if (!push[j] && pop[j]) count_d[j] = count_q[j] - (LOG_D+1)'(1);
      if (valid_out[j]) begin
        addr_out[j*ADDR_W +: ADDR_W] = mem_q[j][rd_ptr_q[j]][ENT_W-1 -: ADDR_W];
        data_out[j*DATA_W +: DATA_W] = mem_q[j][rd_ptr_q[j]][DATA_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < NUM_PORTS; j++) begin
        wr_ptr_q[j] <= '0;
        rd_ptr_q[j] <= '0;
        count_q[j]  <= '0;
        rr_ptr_q[j] <= '0;
      end
`ifdef PKT_SWITCH_BCAST_EN
      bc_rr_q <= '0;
`endif
    end else begin
      for (int j = 0; j < NUM_PORTS; j++) begin
        if (push[j]) mem_q[j][wr_ptr_q[j]] <= wr_ent[j];
        wr_ptr_q[j] <= wr_ptr_d[j];
        rd_ptr_q[j] <= rd_ptr_d[j];
        count_q[j]  <= count_d[j];
        rr_ptr_q[j] <= rr_ptr_d[j];
      end
`ifdef PKT_SWITCH_BCAST_EN
      bc_rr_q <= bc_rr_d;
`endif
    end
  end

endmodule

// File: tb/tb_pkt_switch.sv
// Self-checking bench for pkt_switch: directed vector table followed by randomized traffic
// compared against a queue-based reference model.
module tb_pkt_switch;
  localparam int NP = 4;
  localparam int DW = 8;
  localparam int AW = 8;
  localparam int FD = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr_in, data_in, addr_out, data_out;
  logic [3:0]  valid_in, rcv_rdy, valid_out, data_rd;

  always #5 clk = ~clk;

  pkt_switch #(.NUM_PORTS(NP), .DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset(reset), .addr_in(addr_in), .data_in(data_in), .valid_in(valid_in),
    .rcv_rdy(rcv_rdy), .addr_out(addr_out), .data_out(data_out), .valid_out(valid_out),
    .data_rd(data_rd)
  );

  int n_vec = 0;
  int n_mis = 0;

  typedef struct {
    logic        rst;
    logic [3:0]  vin;
    logic [31:0] ain;
    logic [31:0] din;
    logic [3:0]  rd;
    logic [3:0]  e_rdy;
    logic [3:0]  e_vout;
    logic [31:0] e_aout;
    logic [31:0] e_dout;
  } vec_t;

  vec_t tbl[$];

  typedef logic [15:0] q_t[$];
  q_t mq[NP];
  int rr[NP];

  task automatic add(input logic r, input logic [3:0] vin, input logic [31:0] ain,
                     input logic [31:0] din, input logic [3:0] rd, input logic [3:0] erdy,
                     input logic [3:0] evout, input logic [31:0] eaout, input logic [31:0] edout);
    vec_t v;
    v.rst = r; v.vin = vin; v.ain = ain; v.din = din; v.rd = rd;
    v.e_rdy = erdy; v.e_vout = evout; v.e_aout = eaout; v.e_dout = edout;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [3:0] erdy, input logic [3:0] evout,
                               input logic [31:0] eaout, input logic [31:0] edout);
    chk({tag, " rcv_rdy"},   32'(rcv_rdy),   32'(erdy));
    chk({tag, " valid_out"}, 32'(valid_out), 32'(evout));
    chk({tag, " addr_out"},  addr_out,       eaout);
    chk({tag, " data_out"},  data_out,       edout);
  endtask

  task automatic apply(input vec_t v, input int n);
    @(negedge clk);
    reset    = v.rst;
    valid_in = v.vin;
    addr_in  = v.ain;
    data_in  = v.din;
    data_rd  = v.rd;
    #1;
    check_outputs($sformatf("vec%0d", n), v.e_rdy, v.e_vout, v.e_aout, v.e_dout);
  endtask

  task automatic rand_cycle(input int n);
    logic [3:0]  vin, rd, erdy, evout;
    logic [31:0] ain, din, eaout, edout;
    int          gnt[NP];
    @(negedge clk);
    vin = 4'($urandom);
    rd  = 4'($urandom);
    for (int i = 0; i < NP; i++) begin
      ain[i*8 +: 8] = 8'($urandom_range(0, 254));
      din[i*8 +: 8] = 8'($urandom);
    end
    erdy = '0; evout = '0; eaout = '0; edout = '0;
    for (int j = 0; j < NP; j++) begin
      gnt[j] = -1;
      if (mq[j].size() < FD) begin
        for (int k = 0; k < NP; k++) begin
          int i;
          i = (rr[j] + k) % NP;
          if (vin[i] && int'(ain[i*8 +: 2]) == j) begin
            gnt[j]  = i;
            erdy[i] = 1'b1;
            break;
          end
        end
      end
      if (mq[j].size() > 0) begin
        evout[j] = 1'b1;
        {eaout[j*8 +: 8], edout[j*8 +: 8]} = mq[j][0];
      end
    end
    reset = 1'b0; valid_in = vin; addr_in = ain; data_in = din; data_rd = rd;
    #1;
    check_outputs($sformatf("rnd%0d", n), erdy, evout, eaout, edout);
    @(posedge clk);
    for (int j = 0; j < NP; j++)
      if (rd[j] && mq[j].size() > 0) void'(mq[j].pop_front());
    for (int j = 0; j < NP; j++) begin
      if (gnt[j] >= 0) begin
        mq[j].push_back({ain[gnt[j]*8 +: 8], din[gnt[j]*8 +: 8]});
        rr[j] = (gnt[j] + 1) % NP;
      end
    end
  endtask

  initial begin
    reset = 1'b1; valid_in = 4'hF; addr_in = 32'h03020100; data_in = 32'h0; data_rd = 4'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs("reset", 4'h0, 4'h0, 32'h0, 32'h0);

    // single word in0 -> out2, then pop
    add(0, 4'b0001, 32'h00000002, 32'h000000A5, 4'b0000, 4'b0001, 4'b0000, 32'h0, 32'h0);
    add(0, 4'b0000, 32'h0, 32'h0, 4'b0000, 4'b0000, 4'b0100, 32'h00020000, 32'h00A50000);
    add(0, 4'b0000, 32'h0, 32'h0, 4'b0100, 4'b0000, 4'b0100, 32'h00020000, 32'h00A50000);
    add(0, 4'b0000, 32'h0, 32'h0, 4'b0000, 4'b0000, 4'b0000, 32'h0, 32'h0);
    // five words to out3: fill, stall, pop frees slot next cycle
    add(0, 4'b0001, 32'h3, 32'h10, 4'b0000, 4'b0001, 4'b0000, 32'h0, 32'h0);
    add(0, 4'b0001, 32'h3, 32'h11, 4'b0000, 4'b0001, 4'b1000, 32'h03000000, 32'h10000000);
    add(0, 4'b0001, 32'h3, 32'h12, 4'b0000, 4'b0001, 4'b1000, 32'h03000000, 32'h10000000);
    add(0, 4'b0001, 32'h3, 32'h13, 4'b0000, 4'b0001, 4'b1000, 32'h03000000, 32'h10000000);
    add(0, 4'b0001, 32'h3, 32'h14, 4'b1000, 4'b0000, 4'b1000, 32'h03000000, 32'h10000000);
    add(0, 4'b0001, 32'h3, 32'h14, 4'b0000, 4'b0001, 4'b1000, 32'h03000000, 32'h11000000);
    add(0, 4'b0000, 32'h0, 32'h0, 4'b1000, 4'b0000, 4'b1000, 32'h03000000, 32'h11000000);
    add(0, 4'b0000, 32'h0, 32'h0, 4'b1000, 4'b0000, 4'b1000, 32'h03000000, 32'h12000000);
    add(0, 4'b0000, 32'h0, 32'h0, 4'b1000, 4'b0000, 4'b1000, 32'h03000000, 32'h13000000);
    add(0, 4'b0000, 32'h0, 32'h0, 4'b1000, 4'b0000, 4'b1000, 32'h03000000, 32'h14000000);
    add(0, 4'b0000, 32'h0, 32'h0, 4'b0000, 4'b0000, 4'b0000, 32'h0, 32'h0);
    // all inputs to out1 with continuous pop: grants rotate
    add(0, 4'hF, 32'h01010101, 32'h43424140, 4'b0010, 4'b0001, 4'b0000, 32'h0, 32'h0);
    add(0, 4'hF, 32'h01010101, 32'h43424140, 4'b0010, 4'b0010, 4'b0010, 32'h00000100, 32'h00004000);
    add(0, 4'hF, 32'h01010101, 32'h43424140, 4'b0010, 4'b0100, 4'b0010, 32'h00000100, 32'h00004100);
    add(0, 4'hF, 32'h01010101, 32'h43424140, 4'b0010, 4'b1000, 4'b0010, 32'h00000100, 32'h00004200);
    add(0, 4'hF, 32'h01010101, 32'h43424140, 4'b0010, 4'b0001, 4'b0010, 32'h00000100, 32'h00004300);
    add(0, 4'b0000, 32'h0, 32'h0, 4'b0010, 4'b0000, 4'b0010, 32'h00000100, 32'h00004000);
    add(0, 4'b0000, 32'h0, 32'h0, 4'b0000, 4'b0000, 4'b0000, 32'h0, 32'h0);
    // queue three on out0 (addr 0x04 keeps upper bits), reset mid-stream
    add(0, 4'b0001, 32'h04, 32'h51, 4'b0000, 4'b0001, 4'b0000, 32'h0, 32'h0);
    add(0, 4'b0001, 32'h04, 32'h52, 4'b0000, 4'b0001, 4'b0001, 32'h04, 32'h51);
    add(0, 4'b0001, 32'h04, 32'h53, 4'b0000, 4'b0001, 4'b0001, 32'h04, 32'h51);
    add(1, 4'b0001, 32'h04, 32'h54, 4'b0000, 4'b0000, 4'b0001, 32'h04, 32'h51);
    add(0, 4'b0001, 32'h04, 32'h55, 4'b0000, 4'b0001, 4'b0000, 32'h0, 32'h0);
    add(0, 4'b0000, 32'h0, 32'h0, 4'b0001, 4'b0000, 4'b0001, 32'h04, 32'h55);
    add(0, 4'b0000, 32'h0, 32'h0, 4'b0000, 4'b0000, 4'b0000, 32'h0, 32'h0);
    // all-ones address from in2
    add(0, 4'b0100, 32'h00FF0000, 32'h003C0000, 4'b0000, 4'b0100, 4'b0000, 32'h0, 32'h0);
`ifdef PKT_SWITCH_BCAST_EN
    add(0, 4'b0000, 32'h0, 32'h0, 4'b0000, 4'b0000, 4'b1111, 32'hFFFFFFFF, 32'h3C3C3C3C);
    add(0, 4'b0000, 32'h0, 32'h0, 4'b1111, 4'b0000, 4'b1111, 32'hFFFFFFFF, 32'h3C3C3C3C);
`else
    add(0, 4'b0000, 32'h0, 32'h0, 4'b0000, 4'b0000, 4'b1000, 32'hFF000000, 32'h3C000000);
    add(0, 4'b0000, 32'h0, 32'h0, 4'b1111, 4'b0000, 4'b1000, 32'hFF000000, 32'h3C000000);
`endif
    add(0, 4'b0000, 32'h0, 32'h0, 4'b0000, 4'b0000, 4'b0000, 32'h0, 32'h0);

    for (int n = 0; n < tbl.size(); n++) apply(tbl[n], n);

    @(negedge clk);
    reset = 1'b1; valid_in = 4'h0; data_rd = 4'h0;
    @(posedge clk);
    for (int j = 0; j < NP; j++) begin
      mq[j].delete();
      rr[j] = 0;
    end
    for (int n = 0; n < 500; n++) rand_cycle(n);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
